// File: rtl/dict_pkg.sv
// Shared types and constants for the dictionary encoder and its CAM.
package dict_pkg;

   typedef logic [31:0] data32_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_OUT
   } encoder_state_t;

   // Truncated to the ID width at the point of use, so this is all-ones for any id_t.
   localparam logic [31:0] DICT_ID_OVERFLOW = '1;

endpackage

// File: rtl/dictionary_encoder_if.sv
// N-lane data stream with per-lane keep, last marker and valid/ready handshake.
interface ndata_i #(
   parameter type data_t = logic [31:0],
   parameter int  N      = 1
);
   data_t [N-1:0] data;
   logic  [N-1:0] keep;
   logic          last;
   logic          valid;
   logic          ready;

   modport m (output data, keep, last, valid, input ready);
   modport s (input data, keep, last, valid, output ready);
endinterface

// File: rtl/dict_cam.sv
// Fully associative value CAM: one write port, synchronous clear, combinational
// lookup returning the lowest matching index. Clear wins over a same-cycle write.
module dict_cam
   import dict_pkg::*;
#(
   parameter type value_t   = data32_t,
   parameter int  DICT_SIZE = 64
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         we,
   input  logic [$clog2(DICT_SIZE)-1:0] waddr,
   input  value_t                       wvalue,
   input  logic                         clr,
   input  value_t                       cmp_value,
   output logic                         hit,
   output logic [$clog2(DICT_SIZE)-1:0] hit_idx
);
   localparam int IW = $clog2(DICT_SIZE);

   logic   [DICT_SIZE-1:0] valid_q, valid_d;
   value_t [DICT_SIZE-1:0] entries_q, entries_d;

   always_comb begin
      valid_d   = valid_q;
      entries_d = entries_q;
      if (we) begin
         valid_d[waddr]   = 1'b1;
         entries_d[waddr] = wvalue;
      end
      if (clr) begin
         valid_d = '0;
      end
   end

   // Descending scan so the lowest matching index is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = DICT_SIZE - 1; i >= 0; i--) begin
         if (valid_q[i] && (entries_q[i] == cmp_value)) begin
            hit     = 1'b1;
            hit_idx = IW'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      entries_q <= entries_d;
   end

endmodule

// File: rtl/dictionary_encoder.sv
// Streaming dictionary encoder: values in, IDs out, new values on out_dict in ID order.
// One lane per cycle after capture; stalls on out_dict/out_ids ready, accepts input only when idle.
module dictionary_encoder
   import dict_pkg::*;
#(
   parameter int  NUM_ELEMENTS = 8,
   parameter int  DICT_SIZE    = 64,
   parameter type value_t      = data32_t,
   parameter type id_t         = logic [$clog2(DICT_SIZE)-1:0]
) (
   input  logic                       clk,
   input  logic                       rst_n,
   ndata_i.s                          in_values,
   ndata_i.m                          out_ids,
   ndata_i.m                          out_dict,
   output logic [$clog2(DICT_SIZE):0] dict_count,
   output logic                       overflow
);
   localparam int IW = $clog2(DICT_SIZE);
   localparam int CW = IW + 1;
   localparam int LW = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;

   encoder_state_t            state_q, state_d;
   logic   [LW-1:0]           lane_q, lane_d;
   value_t [NUM_ELEMENTS-1:0] beat_dat_q, beat_dat_d;
   logic   [NUM_ELEMENTS-1:0] beat_keep_q, beat_keep_d;
   logic                      beat_last_q, beat_last_d;
   id_t    [NUM_ELEMENTS-1:0] ids_q, ids_d;
   logic   [NUM_ELEMENTS-1:0] ids_keep_q, ids_keep_d;
   logic   [CW-1:0]           dict_count_q, dict_count_d;
   logic                      overflow_q, overflow_d;

   value_t          cur_value;
   logic            cur_keep;
   logic            cam_hit;
   logic [IW-1:0]   cam_idx;
   logic            cam_we;
   logic            cam_clr;
   logic            room;
   logic            need_alloc;
   logic            advance;

   assign cur_value  = beat_dat_q[lane_q];
   assign cur_keep   = beat_keep_q[lane_q];
   assign room       = dict_count_q < CW'(DICT_SIZE);
   // Depends only on registered state, so the request stays up until accepted.
   assign need_alloc = (state_q == S_SCAN) && cur_keep && !cam_hit && room;

   dict_cam #(
      .value_t   (value_t),
      .DICT_SIZE (DICT_SIZE)
   ) u_cam (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (cam_we),
      .waddr     (dict_count_q[IW-1:0]),
      .wvalue    (cur_value),
      .clr       (cam_clr),
      .cmp_value (cur_value),
      .hit       (cam_hit),
      .hit_idx   (cam_idx)
   );

   assign in_values.ready = (state_q == S_IDLE);

   assign out_dict.valid   = need_alloc;
   assign out_dict.data[0] = cur_value;
   assign out_dict.keep    = '1;
   assign out_dict.last    = 1'b0;

   assign out_ids.valid = (state_q == S_OUT);
   assign out_ids.data  = ids_q;
   assign out_ids.keep  = ids_keep_q;
   assign out_ids.last  = beat_last_q;

   assign dict_count = dict_count_q;
   assign overflow   = overflow_q;

   always_comb begin
      state_d      = state_q;
      lane_d       = lane_q;
      beat_dat_d   = beat_dat_q;
      beat_keep_d  = beat_keep_q;
      beat_last_d  = beat_last_q;
      ids_d        = ids_q;
      ids_keep_d   = ids_keep_q;
      dict_count_d = dict_count_q;
      overflow_d   = overflow_q;
      cam_we       = 1'b0;
      cam_clr      = 1'b0;
      advance      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (in_values.valid) begin
               beat_dat_d  = in_values.data;
               beat_keep_d = in_values.keep;
               beat_last_d = in_values.last;
               lane_d      = '0;
               state_d     = S_SCAN;
            end
         end

         S_SCAN: begin
            if (!cur_keep) begin
               ids_d[lane_q]      = '0;
               ids_keep_d[lane_q] = 1'b0;
               advance            = 1'b1;
            end else if (cam_hit) begin
               ids_d[lane_q]      = id_t'(cam_idx);
               ids_keep_d[lane_q] = 1'b1;
               advance            = 1'b1;
            end else if (room) begin
               if (out_dict.ready) begin
                  cam_we             = 1'b1;
                  ids_d[lane_q]      = id_t'(dict_count_q[IW-1:0]);
                  ids_keep_d[lane_q] = 1'b1;
                  dict_count_d       = dict_count_q + CW'(1);
                  advance            = 1'b1;
               end
            end else begin
               ids_d[lane_q]      = id_t'(DICT_ID_OVERFLOW);
               ids_keep_d[lane_q] = 1'b1;
               overflow_d         = 1'b1;
               advance            = 1'b1;
            end

            if (advance) begin
               if (lane_q == LW'(NUM_ELEMENTS - 1)) begin
                  lane_d  = '0;
                  state_d = S_OUT;
               end else begin
                  lane_d = lane_q + LW'(1);
               end
            end
         end

         S_OUT: begin
            if (out_ids.ready) begin
               state_d = S_IDLE;
               // Stream end: the next stream starts with an empty dictionary.
               if (beat_last_q) begin
                  cam_clr      = 1'b1;
                  dict_count_d = '0;
                  overflow_d   = 1'b0;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         lane_q       <= '0;
         beat_dat_q   <= '0;
         beat_keep_q  <= '0;
         beat_last_q  <= 1'b0;
         ids_q        <= '0;
         ids_keep_q   <= '0;
         dict_count_q <= '0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         lane_q       <= lane_d;
         beat_dat_q   <= beat_dat_d;
         beat_keep_q  <= beat_keep_d;
         beat_last_q  <= beat_last_d;
         ids_q        <= ids_d;
         ids_keep_q   <= ids_keep_d;
         dict_count_q <= dict_count_d;
         overflow_q   <= overflow_d;
      end
   end

endmodule

// File: tb/tb_dictionary_encoder.sv
// Directed bench for dictionary_encoder with 4 lanes and a 4-entry dictionary.
module tb_dictionary_encoder;
   import dict_pkg::*;

   localparam int N = 4;
   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] dict_count;
   logic       overflow;

   ndata_i #(.data_t(logic [31:0]), .N(N)) in_if ();
   ndata_i #(.data_t(logic [1:0]),  .N(N)) ids_if ();
   ndata_i #(.data_t(logic [31:0]), .N(1)) dict_if ();

   dictionary_encoder #(
      .NUM_ELEMENTS (N),
      .DICT_SIZE    (D)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_values  (in_if),
      .out_ids    (ids_if),
      .out_dict   (dict_if),
      .dict_count (dict_count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [31:0] dq[$];

   always @(posedge clk) begin
      if (rst_n && dict_if.valid && dict_if.ready) dq.push_back(dict_if.data[0]);
   end

   typedef struct {
      logic [3:0][31:0] v;
      logic [3:0]       keep;
      logic             last;
      logic [3:0][1:0]  ids;
      logic [3:0]       okeep;
      int               nd;
      logic [3:0][31:0] d;
      logic [2:0]       cnt;
      logic             ovf;
   } vec_t;

   vec_t tbl[7];

   function automatic vec_t mk(input logic [3:0][31:0] v, input logic [3:0] keep, input logic last,
                               input logic [7:0] ids, input logic [3:0] okeep, input int nd,
                               input logic [3:0][31:0] d, input logic [2:0] cnt, input logic ovf);
      vec_t r;
      r.v = v; r.keep = keep; r.last = last; r.ids = ids; r.okeep = okeep;
      r.nd = nd; r.d = d; r.cnt = cnt; r.ovf = ovf;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [3:0][31:0] v, input logic [3:0] k, input logic l);
      int t = 0;
      @(negedge clk);
      in_if.data = v; in_if.keep = k; in_if.last = l; in_if.valid = 1'b1;
      while (!in_if.ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("in_accept", 64'(in_if.ready), 64'd1);
      @(posedge clk);
      #1 in_if.valid = 1'b0;
   endtask

   task automatic wait_ids(output bit ok);
      int t = 0;
      while (!ids_if.valid && t < 200) begin
         @(negedge clk);
         t++;
      end
      ok = ids_if.valid;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL ids_timeout: got valid=0 expected valid=1");
      end
   endtask

   task automatic ack_ids();
      ids_if.ready = 1'b1;
      @(posedge clk);
      #1 ids_if.ready = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit ok;
      int t;
      logic [7:0] held_ids;

      in_if.data = '0; in_if.keep = '0; in_if.last = 1'b0; in_if.valid = 1'b0;
      ids_if.ready = 1'b0;
      dict_if.ready = 1'b1;

      // Five dictionary beats include 1..4 for the overflow stream; last column is stream end.
      tbl[0] = mk({32'd9, 32'd5, 32'd7, 32'd5}, 4'hF, 1'b1, {2'd2, 2'd0, 2'd1, 2'd0}, 4'hF, 3,
                  {32'd0, 32'd9, 32'd7, 32'd5}, 3'd3, 1'b0);
      tbl[1] = mk({32'd0, 32'd0, 32'd5, 32'd9}, 4'b0011, 1'b1, {2'd0, 2'd0, 2'd1, 2'd0}, 4'b0011, 2,
                  {32'd0, 32'd0, 32'd5, 32'd9}, 3'd2, 1'b0);
      tbl[2] = mk({32'd4, 32'd3, 32'd2, 32'd1}, 4'hF, 1'b0, {2'd3, 2'd2, 2'd1, 2'd0}, 4'hF, 4,
                  {32'd4, 32'd3, 32'd2, 32'd1}, 3'd4, 1'b0);
      tbl[3] = mk({32'd2, 32'd6, 32'd1, 32'd5}, 4'hF, 1'b1, {2'd1, 2'd3, 2'd0, 2'd3}, 4'hF, 0,
                  {32'd0, 32'd0, 32'd0, 32'd0}, 3'd4, 1'b1);
      tbl[4] = mk({32'd3, 32'd3, 32'd3, 32'd3}, 4'hF, 1'b0, {2'd0, 2'd0, 2'd0, 2'd0}, 4'hF, 1,
                  {32'd0, 32'd0, 32'd0, 32'd3}, 3'd1, 1'b0);
      tbl[5] = mk({32'd8, 32'd3, 32'd8, 32'd3}, 4'hF, 1'b0, {2'd1, 2'd0, 2'd1, 2'd0}, 4'hF, 1,
                  {32'd0, 32'd0, 32'd0, 32'd8}, 3'd2, 1'b0);
      tbl[6] = mk({32'd0, 32'd0, 32'd3, 32'd8}, 4'b0000, 1'b1, {2'd0, 2'd0, 2'd0, 2'd0}, 4'b0000, 0,
                  {32'd0, 32'd0, 32'd0, 32'd0}, 3'd2, 1'b0);

      #1;
      chk("rst_in_ready", 64'(in_if.ready), 64'd1);
      chk("rst_ids_valid", 64'(ids_if.valid), 64'd0);
      chk("rst_dict_valid", 64'(dict_if.valid), 64'd0);
      chk("rst_dict_count", 64'(dict_count), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         dq.delete();
         send(tbl[i].v, tbl[i].keep, tbl[i].last);
         wait_ids(ok);
         if (ok) begin
            chk($sformatf("v%0d_ids", i), 64'(ids_if.data), 64'(tbl[i].ids));
            chk($sformatf("v%0d_keep", i), 64'(ids_if.keep), 64'(tbl[i].okeep));
            chk($sformatf("v%0d_last", i), 64'(ids_if.last), 64'(tbl[i].last));
            chk($sformatf("v%0d_count", i), 64'(dict_count), 64'(tbl[i].cnt));
            chk($sformatf("v%0d_ovf", i), 64'(overflow), 64'(tbl[i].ovf));
            chk($sformatf("v%0d_in_ready_busy", i), 64'(in_if.ready), 64'd0);
            ack_ids();
            chk($sformatf("v%0d_ndict", i), 64'(dq.size()), 64'(tbl[i].nd));
            for (int j = 0; j < tbl[i].nd && j < dq.size(); j++)
               chk($sformatf("v%0d_dict%0d", i, j), 64'(dq[j]), 64'(tbl[i].d[j]));
            if (tbl[i].last) begin
               chk($sformatf("v%0d_count_clr", i), 64'(dict_count), 64'd0);
               chk($sformatf("v%0d_ovf_clr", i), 64'(overflow), 64'd0);
            end
            chk($sformatf("v%0d_in_ready_idle", i), 64'(in_if.ready), 64'd1);
         end
      end

      // Backpressure on both output streams: beat [4,4,6,6], last.
      dq.delete();
      dict_if.ready = 1'b0;
      send({32'd6, 32'd6, 32'd4, 32'd4}, 4'hF, 1'b1);
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("bp_dict_valid%0d", c), 64'(dict_if.valid), 64'd1);
         chk($sformatf("bp_dict_data%0d", c), 64'(dict_if.data[0]), 64'd4);
         chk($sformatf("bp_in_ready%0d", c), 64'(in_if.ready), 64'd0);
         @(posedge clk);
         #1;
      end
      dict_if.ready = 1'b1;
      wait_ids(ok);
      if (ok) begin
         held_ids = ids_if.data;
         chk("bp_ids", 64'(held_ids), 64'b01_01_00_00);
         for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_ids_valid%0d", c), 64'(ids_if.valid), 64'd1);
            chk($sformatf("bp_ids_stable%0d", c), 64'(ids_if.data), 64'b01_01_00_00);
            chk($sformatf("bp_ids_in_ready%0d", c), 64'(in_if.ready), 64'd0);
         end
         ack_ids();
      end
      chk("bp_ndict", 64'(dq.size()), 64'd2);
      if (dq.size() >= 2) begin
         chk("bp_dict0", 64'(dq[0]), 64'd4);
         chk("bp_dict1", 64'(dq[1]), 64'd6);
      end
      chk("bp_count_clr", 64'(dict_count), 64'd0);

      // Asynchronous reset while scanning with two entries allocated.
      dq.delete();
      send({32'd13, 32'd12, 32'd11, 32'd10}, 4'hF, 1'b1);
      t = 0;
      while (dict_count != 3'd2 && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("ar_pre_count", 64'(dict_count), 64'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_in_ready", 64'(in_if.ready), 64'd1);
      chk("ar_ids_valid", 64'(ids_if.valid), 64'd0);
      chk("ar_dict_valid", 64'(dict_if.valid), 64'd0);
      chk("ar_count", 64'(dict_count), 64'd0);
      chk("ar_overflow", 64'(overflow), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dq.delete();
      send({32'd0, 32'd0, 32'd0, 32'd7}, 4'b0001, 1'b1);
      wait_ids(ok);
      if (ok) begin
         chk("ar_ids", 64'(ids_if.data), 64'd0);
         chk("ar_keep", 64'(ids_if.keep), 64'b0001);
         chk("ar_count_next", 64'(dict_count), 64'd1);
         ack_ids();
      end
      chk("ar_ndict", 64'(dq.size()), 64'd1);
      if (dq.size() >= 1) chk("ar_dict0", 64'(dq[0]), 64'd7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
